// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_state_e;

  // x0 is hardwired to zero and never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 5;

  // Pipeline control word driven toward the stage registers
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic pcsrc;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_hold;
  } pipe_ctrl_t;

  // Control word for an unstalled, unflushed cycle
  function automatic pipe_ctrl_t ctrl_normal();
    pipe_ctrl_t c;
    c            = '0;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Data-memory request/ready handshake between the sequencer and the MEM stage.
interface pipeline_ctrl_if;
  logic dmem_req;
  logic dmem_ready;

  modport master (output dmem_req, input dmem_ready);
  modport slave  (input dmem_req, output dmem_ready);
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX whose rd feeds the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       idex_memtoreg,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  output logic       load_use_stall
);

  // Stall when the load destination matches either source of the ID instruction
  always_comb begin
    load_use_stall = idex_memtoreg & (idex_rd != REG_ZERO) &
                     ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional build macro PIPE_PERF_CNT_EN adds stall_cycles / flush_events counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic [4:0] idex_rd,
  input  logic       idex_memtoreg,
  input  logic       exmem_branch,
  input  logic       exmem_zero,
  input  logic       exmem_memtoreg,
  input  logic       exmem_memwrite,
  pipeline_ctrl_if.master dmem,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       pcsrc,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       pipe_hold,
  output logic       mem_error
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_ERROR    = ERROR;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_error_q, mem_error_d;

  logic       mem_op;
  logic       in_error;
  logic       hold_mem;
  logic       take_branch;
  logic       load_use_stall;
  pipe_ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .idex_memtoreg  (idex_memtoreg),
    .idex_rd        (idex_rd),
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2),
    .load_use_stall (load_use_stall)
  );

  // Hazard qualifiers derived from the current state and MEM-stage inputs
  always_comb begin
    mem_op      = exmem_memtoreg | exmem_memwrite;
    in_error    = (state_q == S_ERROR);
    hold_mem    = mem_op & ~dmem.dmem_ready & ~in_error;
    take_branch = exmem_branch & exmem_zero;
  end

  // Next-state logic for the FSM, wait counter and sticky error flag
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      S_RUN: begin
        if (hold_mem) begin
          state_d = S_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (dmem.dmem_ready || !mem_op) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d     = S_ERROR;
          mem_error_d = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERROR: begin
        mem_error_d = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Priority mux: error > memory hold > taken branch > load-use > normal
  always_comb begin
    ctrl = ctrl_normal();
    if (reset) begin
      ctrl = '0;
    end else if (in_error || hold_mem) begin
      ctrl           = '0;
      ctrl.pipe_hold = 1'b1;
    end else if (take_branch) begin
      ctrl.pcsrc       = 1'b1;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (load_use_stall) begin
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      ctrl.idex_flush = 1'b1;
    end
  end

  // Drive the control word and handshake onto the ports
  always_comb begin
    pc_write      = ctrl.pc_write;
    ifid_write    = ctrl.ifid_write;
    pcsrc         = ctrl.pcsrc;
    ifid_flush    = ctrl.ifid_flush;
    idex_flush    = ctrl.idex_flush;
    exmem_flush   = ctrl.exmem_flush;
    pipe_hold     = ctrl.pipe_hold;
    mem_error     = mem_error_q & ~reset;
    dmem.dmem_req = mem_op & ~in_error & ~reset;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Count stalled cycles and applied taken branches; both wrap naturally
  always_comb begin
    stall_cycles_d = stall_cycles_q + 32'(~ctrl.pc_write & ~reset);
    flush_events_d = flush_events_q + 32'(ctrl.pcsrc);
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
